// File: rtl/line_memory.sv
// Line-granular backing memory serving cache fills and writebacks with a fixed,
// parameterised access latency and a busywait/done handshake.
//
// state | meaning
// IDLE  | waiting for a line request; write wins over read
// BUSY  | access in flight, cnt counts down to the completion edge
// DONE  | one-cycle done pulse, requests ignored
module line_memory #(
  parameter int BLOCK_SIZE   = 2,
  parameter int LINE_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int LATENCY      = 4,
  parameter int DEPTH_LINES  = 256
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   m_read_i,
  input  logic                                   m_wr_i,
  input  logic [ADDRESS_SIZE-BLOCK_SIZE-3:0]     m_addr_i,
  input  logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_wr_data_i,
  output logic                                   m_busywait_o,
  output logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_read_data_o,
  output logic                                   m_write_done_o,
  output logic                                   m_read_done_o
);

  localparam int LINE_W = (2**BLOCK_SIZE) * LINE_SIZE;
  localparam int ADDR_W = ADDRESS_SIZE - BLOCK_SIZE - 2;
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   data_q;
  logic                op_wr_q;
  logic                busy_q;
  logic                rdone_q;
  logic                wdone_q;
  logic [LINE_W-1:0]   rdata_q;

  logic                accept;
  logic                complete;
  logic                mem_we;
  logic                rd_load;

  logic [LINE_W-1:0]   mem [DEPTH_LINES];

  // Upper line-address bits alias onto the stored lines and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^m_addr_i[ADDR_W-1:IDX_W];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (m_wr_i || m_read_i) state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: accept = m_wr_i || m_read_i;
      S_BUSY: complete = (cnt_q == '0);
      default: ;
    endcase
    mem_we  = complete && op_wr_q;
    rd_load = complete && !op_wr_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      op_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q   <= m_addr_i[IDX_W-1:0];
        op_wr_q <= m_wr_i;
        cnt_q   <= CNT_W'(LATENCY - 1);
        busy_q  <= 1'b1;
        if (m_wr_i) data_q <= m_wr_data_i;
      end else if (state_q == S_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (complete) begin
        busy_q  <= 1'b0;
        rdone_q <= !op_wr_q;
        wdone_q <= op_wr_q;
      end
      if (rd_load) rdata_q <= mem[idx_q];
      if (state_q == S_DONE) begin
        rdone_q <= 1'b0;
        wdone_q <= 1'b0;
      end
    end
  end

  // Storage is never cleared by reset; a write only lands on its completion edge,
  // so a reset during BUSY leaves the old line intact.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= data_q;
  end

  assign m_busywait_o   = busy_q;
  assign m_read_done_o  = rdone_q;
  assign m_write_done_o = wdone_q;
  assign m_read_data_o  = rdata_q;

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Line-granular backing memory with a fixed access latency.
- Sits directly downstream of the cache and serves its miss fills and dirty-line writebacks over the cache's memory-side handshake (read/write request, busywait, read_done/write_done).
- One transfer is a full cache line of 2**BLOCK_SIZE words, addressed by line address.
- Replaces the behavioural memory model with a synthesizable, latency-parameterised block.

Parameters:
- BLOCK_SIZE, 2: log2 of words per line.
- LINE_SIZE, 32: word width in bits.
- ADDRESS_SIZE, 32: CPU byte-address width.
- LATENCY, 4: cycles from request acceptance to completion; legal range is 1 or more.
- DEPTH_LINES, 256: number of stored lines; must be a power of 2.

Ports:
- clk_i  input  1  Clock; all state changes on the rising edge.
- reset_i  input  1  Asynchronous, active-low reset.
- m_read_i  input  1  Line read request.
- m_wr_i  input  1  Line write request.
- m_addr_i  input  ADDRESS_SIZE-BLOCK_SIZE-2  Line address.
- m_wr_data_i  input  2**BLOCK_SIZE*LINE_SIZE  Write line; word 0 is in bits [LINE_SIZE-1:0].
- m_busywait_o  output  1  High while an access is in flight.
- m_read_data_o  output  2**BLOCK_SIZE*LINE_SIZE  Read line; holds its value until the next read completes.
- m_write_done_o  output  1  One-cycle write completion pulse.
- m_read_done_o  output  1  One-cycle read completion pulse.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=IDLE, cnt=0.
  - m_busywait_o, m_read_done_o, m_write_done_o and m_read_data_o all 0.
  - Storage array is not cleared.
- Index: idx = m_addr_i[log2(DEPTH_LINES)-1:0]. Upper address bits are ignored, so addresses alias modulo DEPTH_LINES.
- State IDLE:
  - At a clock edge with m_wr_i=1, latch addr, data and op=WRITE, set cnt=LATENCY-1, go to BUSY.
  - Otherwise, with m_read_i=1, latch addr and op=READ, same cnt and transition.
  - Write has priority when both requests are high.
- State BUSY:
  - While cnt!=0, decrement cnt each edge.
  - At the edge where cnt==0:
    - READ: m_read_data_o <= mem[idx] and m_read_done_o <= 1.
    - WRITE: mem[idx] <= latched data and m_write_done_o <= 1.
    - Go to DONE.
- State DONE:
  - Done pulse is high for exactly this cycle.
  - m_busywait_o is 0.
  - Requests are ignored.
  - Next edge: clear the done pulse and go to IDLE.
- m_busywait_o is registered:
  - Goes to 1 at the accepting edge.
  - Goes to 0 at the completion edge, i.e. when entering DONE.
- Timing: request accepted at edge E0 produces done high in the cycle after edge E0+LATENCY. The earliest next acceptance is edge E0+LATENCY+2.
- Request inputs may change or drop after acceptance; only the latched copies are used.
- Requests are not queued. A request held across DONE is accepted at the first edge it is seen while in IDLE.
- Reset mid-operation aborts the access. An in-flight write is not committed, and no done pulse is issued.
- LATENCY=1: the completion edge is the edge immediately after acceptance.
- Counter width is clog2(LATENCY) bits, with a minimum of 1.

Test Plan:
- Reset sequencing:
  - Stimulus: hold reset_i=0 with requests asserted, then release.
  - Required: all outputs stay 0 during reset, no acceptance occurs while in reset, and state is IDLE after release.
- Write then read back:
  - Stimulus: write addr 28'h0000018 with data 128'h0000000D_0000000C_0000000B_0000000A. After write_done, read the same address.
  - Required: m_read_data_o equals the written line.
  - Required: m_read_done_o is high exactly one cycle, 5 cycles after the read acceptance edge (LATENCY=4).
  - Required: busywait is high for 4 cycles.
- Simultaneous request:
  - Stimulus: m_wr_i=1 and m_read_i=1 together, addr 28'h3.
  - Required: only m_write_done_o pulses; m_read_data_o is unchanged.
  - Required: a later read of 28'h3 returns the written data.
- Aliasing:
  - Stimulus: write 128'h1 to addr 28'h005, then read addr 28'h105 (DEPTH_LINES=256).
  - Required: the read returns 128'h1.
- Reset mid-write:
  - Stimulus: write 128'hFF to addr 7, then pull reset_i low in BUSY with cnt=2.
  - Required: no done pulse and busywait=0 immediately.
  - Required: after release, a read of addr 7 returns the prior contents.
- Back-to-back with held request:
  - Stimulus: keep m_read_i=1 continuously.
  - Required: done pulses repeat every LATENCY+2 cycles, and busywait is never high during DONE.
